// File: rtl/ctrl_cmd_rx_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_cmd_rx_pkg
// Shared constants, command-word field positions and the deserialiser state
// type used by the sys_ctrl command receiver and its sub-module.
// No ports (package).
// ----------------------------------------------------------------------------
package ctrl_cmd_rx_pkg;

    localparam logic [3:0] CMD_MARKER  = 4'hF;
    localparam logic [3:0] ADDR_BCAST  = 4'hF;
    localparam logic [3:0] OP_RESET    = 4'h0;
    localparam logic [3:0] OP_ADC_READ = 4'h2;

    localparam int MARKER_HI = 31;
    localparam int MARKER_LO = 28;
    localparam int ADDR_HI   = 27;
    localparam int ADDR_LO   = 24;
    localparam int OP_HI     = 23;
    localparam int OP_LO     = 20;

    typedef enum logic [1:0] {
        DESER_IDLE,
        DESER_DATA,
        DESER_STOP
    } deserState_e;

    // A word is for us when it carries our address or the broadcast address.
    function automatic logic addrMatch(input logic [3:0] addr, input logic [3:0] moduleId);
        return (addr == moduleId) || (addr == ADDR_BCAST);
    endfunction

endpackage

// File: rtl/ctrl_cmd_rx_if.sv
// ----------------------------------------------------------------------------
// ctrl_cmd_rx_if
// Valid/ready handshake carrying accepted command words from the receiver
// to the front-end controller.
//   cmd_data  : accepted command word (LENGTH bits)
//   cmd_valid : cmd_data valid, held until cmd_ready
//   cmd_ready : consumer accepts when cmd_valid & cmd_ready
// master = receiver side, slave = controller side.
// ----------------------------------------------------------------------------
interface ctrl_cmd_rx_if #(
    parameter int LENGTH = 32
);

    logic [LENGTH-1:0] cmd_data;
    logic              cmd_valid;
    logic              cmd_ready;

    modport master (
        output cmd_data,
        output cmd_valid,
        input  cmd_ready
    );

    modport slave (
        input  cmd_data,
        input  cmd_valid,
        output cmd_ready
    );

endinterface

// File: rtl/ctrl_cmd_rx_deser.sv
// ----------------------------------------------------------------------------
// ctrl_line_deser
// Synchronises the serial sys_ctrl line and deserialises start/data/stop
// frames (start 0, LENGTH bits MSB first, stop 1, no idle gap required).
// Ports:
//   clk        : system clock, one line bit per cycle
//   rst_n      : asynchronous active-low reset
//   ctrl_i     : raw serial line (idles high)
//   word_o     : last deserialised word (stable until the next frame shifts)
//   wordOk_o   : one-cycle strobe, good stop bit and marker nibble
//   wordBad_o  : one-cycle strobe, bad stop bit or bad marker nibble
// ----------------------------------------------------------------------------
module ctrl_line_deser
    import ctrl_cmd_rx_pkg::*;
#(
    parameter int LENGTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctrl_i,
    output logic [LENGTH-1:0] word_o,
    output logic              wordOk_o,
    output logic              wordBad_o
);

    localparam int CNT_W = $clog2(LENGTH);

    logic              sync1_q;
    logic              sync2_q;
    logic              lineBit;
    deserState_e       state_q, state_d;
    logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
    logic [LENGTH-1:0] shift_q, shift_d;
    logic              wordOk_q, wordOk_d;
    logic              wordBad_q, wordBad_d;

    assign lineBit = sync2_q;

    // Two-flop synchroniser; resets to the idle level so reset release
    // can never look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= ctrl_i;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DESER_IDLE;
            bitCnt_q  <= '0;
            shift_q   <= '0;
            wordOk_q  <= 1'b0;
            wordBad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitCnt_q  <= bitCnt_d;
            shift_q   <= shift_d;
            wordOk_q  <= wordOk_d;
            wordBad_q <= wordBad_d;
        end
    end

    // In STOP a 0 is a framing error and goes back to IDLE without being
    // taken as the next start bit.
    always_comb begin
        state_d   = state_q;
        bitCnt_d  = bitCnt_q;
        shift_d   = shift_q;
        wordOk_d  = 1'b0;
        wordBad_d = 1'b0;
        case (state_q)
            DESER_IDLE: begin
                if (!lineBit) begin
                    state_d  = DESER_DATA;
                    bitCnt_d = '0;
                end
            end
            DESER_DATA: begin
                shift_d  = {shift_q[LENGTH-2:0], lineBit};
                bitCnt_d = bitCnt_q + 1'b1;
                if (bitCnt_q == CNT_W'(LENGTH - 1)) begin
                    state_d = DESER_STOP;
                end
            end
            DESER_STOP: begin
                state_d = DESER_IDLE;
                if (lineBit && (shift_q[MARKER_HI:MARKER_LO] == CMD_MARKER)) begin
                    wordOk_d = 1'b1;
                end else begin
                    wordBad_d = 1'b1;
                end
            end
            default: begin
                state_d = DESER_IDLE;
            end
        endcase
    end

    assign word_o    = shift_q;
    assign wordOk_o  = wordOk_q;
    assign wordBad_o = wordBad_q;

endmodule

// File: rtl/ctrl_cmd_rx.sv
// ----------------------------------------------------------------------------
// ctrl_cmd_rx
// Front-end command receiver: deserialises sys_ctrl, filters by address,
// turns the reset opcode into a stretched rst_req and queues all other
// commands in a one-deep holding register.
// Ports:
//   clk        : system clock, one line bit per cycle
//   rst_n      : asynchronous active-low reset
//   module_id  : this front-end's address
//   ctrl       : serial command line (idles high)
//   cmd        : valid/ready command output (master modport)
//   rst_req    : soft-reset request, RST_CYCLES long
//   frame_err  : saturating count of bad stop bits / bad marker nibbles
//   ovf_err    : saturating count of words dropped on a full holding reg
// ----------------------------------------------------------------------------
module ctrl_cmd_rx
    import ctrl_cmd_rx_pkg::*;
#(
    parameter int LENGTH     = 32,
    parameter int RST_CYCLES = 16,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       module_id,
    input  logic             ctrl,
    ctrl_cmd_rx_if.master    cmd,
    output logic             rst_req,
    output logic [ERR_W-1:0] frame_err,
    output logic [ERR_W-1:0] ovf_err
);

    localparam int RST_W = $clog2(RST_CYCLES + 1);

    logic [LENGTH-1:0] word;
    logic              wordOk;
    logic              wordBad;
    logic              addrHit;
    logic              isReset;
    logic              loadWord;
    logic              accept;

    logic [LENGTH-1:0] cmdData_q, cmdData_d;
    logic              cmdValid_q, cmdValid_d;
    logic [RST_W-1:0]  rstCnt_q, rstCnt_d;
    logic [ERR_W-1:0]  frameErr_q, frameErr_d;
    logic [ERR_W-1:0]  ovfErr_q, ovfErr_d;

    ctrl_line_deser #(
        .LENGTH (LENGTH)
    ) u_deser (
        .clk       (clk),
        .rst_n     (rst_n),
        .ctrl_i    (ctrl),
        .word_o    (word),
        .wordOk_o  (wordOk),
        .wordBad_o (wordBad)
    );

    assign addrHit  = wordOk && addrMatch(word[ADDR_HI:ADDR_LO], module_id);
    assign isReset  = addrHit && (word[OP_HI:OP_LO] == OP_RESET);
    assign loadWord = addrHit && (word[OP_HI:OP_LO] != OP_RESET);
    assign accept   = cmdValid_q && cmd.cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmdData_q  <= '0;
            cmdValid_q <= 1'b0;
            rstCnt_q   <= '0;
            frameErr_q <= '0;
            ovfErr_q   <= '0;
        end else begin
            cmdData_q  <= cmdData_d;
            cmdValid_q <= cmdValid_d;
            rstCnt_q   <= rstCnt_d;
            frameErr_q <= frameErr_d;
            ovfErr_q   <= ovfErr_d;
        end
    end

    // A new word may replace the held one in the same cycle it is accepted;
    // it is only dropped when the held word is still waiting.
    always_comb begin
        cmdData_d  = cmdData_q;
        cmdValid_d = cmdValid_q;
        rstCnt_d   = rstCnt_q;
        frameErr_d = frameErr_q;
        ovfErr_d   = ovfErr_q;

        if (loadWord) begin
            if (cmdValid_q && !cmd.cmd_ready) begin
                if (ovfErr_q != '1) begin
                    ovfErr_d = ovfErr_q + 1'b1;
                end
            end else begin
                cmdData_d  = word;
                cmdValid_d = 1'b1;
            end
        end else if (accept) begin
            cmdValid_d = 1'b0;
        end

        if (wordBad && (frameErr_q != '1)) begin
            frameErr_d = frameErr_q + 1'b1;
        end

        if (isReset) begin
            rstCnt_d = RST_W'(RST_CYCLES);
        end else if (rstCnt_q != '0) begin
            rstCnt_d = rstCnt_q - 1'b1;
        end
    end

    assign cmd.cmd_data  = cmdData_q;
    assign cmd.cmd_valid = cmdValid_q;
    assign rst_req       = (rstCnt_q != '0);
    assign frame_err     = frameErr_q;
    assign ovf_err       = ovfErr_q;

endmodule

// File: tb/tb_ctrl_cmd_rx.sv
// ----------------------------------------------------------------------------
// tb_ctrl_cmd_rx
// Directed bench for ctrl_cmd_rx. A frame-level model schedules the effect
// of every sent frame LENGTH+5 cycles after its start bit and tracks the
// expected handshake, reset stretcher and error counters; every cycle the
// DUT is compared against it, and hand-computed literals pin the model.
// ----------------------------------------------------------------------------
module tb_ctrl_cmd_rx;
    import ctrl_cmd_rx_pkg::*;

    localparam int LENGTH     = 32;
    localparam int RST_CYCLES = 16;
    localparam int ERR_W      = 8;
    localparam int LATENCY    = LENGTH + 5;
    localparam int MAX_FRAMES = 64;
    localparam int ERR_MAX    = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       module_id = 4'h0;
    logic             ctrl = 1'b1;
    logic             rst_req;
    logic [ERR_W-1:0] frame_err;
    logic [ERR_W-1:0] ovf_err;

    ctrl_cmd_rx_if #(.LENGTH(LENGTH)) cmdIf();

    ctrl_cmd_rx #(
        .LENGTH     (LENGTH),
        .RST_CYCLES (RST_CYCLES),
        .ERR_W      (ERR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .module_id (module_id),
        .ctrl      (ctrl),
        .cmd       (cmdIf),
        .rst_req   (rst_req),
        .frame_err (frame_err),
        .ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    // Frames sent so far: when their effect is due and what they carried.
    typedef struct {
        int          due;
        logic [31:0] word;
        logic        stopOk;
    } frame_t;

    frame_t frames [MAX_FRAMES];
    int     nFrames = 0;

    int nChecks = 0;
    int nFail   = 0;

    // Frame-level model state, advanced once per rising edge.
    int          cyc = 0;
    int          headIdx = 0;
    logic        mValid = 1'b0;
    logic [31:0] mData = '0;
    int          mRstCnt = 0;
    int          mFrameErr = 0;
    int          mOvfErr = 0;

    // Observation counters for the literal checks.
    int          tickCount = 0;
    int          validCount;
    int          firstValid;
    int          rstHigh;
    int          firstRst;
    logic [31:0] seenData;

    always @(posedge clk) begin : modelProc
        logic [31:0] w;
        logic        newWord;
        logic        reload;
        cyc     = cyc + 1;
        newWord = 1'b0;
        reload  = 1'b0;
        w       = '0;
        if (!rst_n) begin
            mValid    = 1'b0;
            mData     = '0;
            mRstCnt   = 0;
            mFrameErr = 0;
            mOvfErr   = 0;
            headIdx   = nFrames;
        end else begin
            if (headIdx < nFrames && frames[headIdx].due == cyc) begin
                w = frames[headIdx].word;
                if (!frames[headIdx].stopOk || w[31:28] != CMD_MARKER) begin
                    if (mFrameErr < ERR_MAX) mFrameErr = mFrameErr + 1;
                end else if (w[27:24] == module_id || w[27:24] == ADDR_BCAST) begin
                    if (w[23:20] == OP_RESET) reload = 1'b1;
                    else newWord = 1'b1;
                end
                headIdx = headIdx + 1;
            end
            if (newWord) begin
                if (mValid && !cmdIf.cmd_ready) begin
                    if (mOvfErr < ERR_MAX) mOvfErr = mOvfErr + 1;
                end else begin
                    mValid = 1'b1;
                    mData  = w;
                end
            end else if (mValid && cmdIf.cmd_ready) begin
                mValid = 1'b0;
            end
            if (reload) mRstCnt = RST_CYCLES;
            else if (mRstCnt > 0) mRstCnt = mRstCnt - 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks = nChecks + 1;
        if (actual !== expected) begin
            nFail = nFail + 1;
            $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic clearObs();
        validCount = 0;
        firstValid = -1;
        rstHigh    = 0;
        firstRst   = -1;
        seenData   = '0;
    endtask

    // One cycle: advance to the falling edge, compare DUT to the model,
    // record observations. Callers drive inputs right after it returns.
    task automatic tick();
        @(negedge clk);
        tickCount = tickCount + 1;
        if (!rst_n) begin
            checkOutput("inreset_valid", {31'b0, cmdIf.cmd_valid}, 32'd0);
            checkOutput("inreset_rst_req", {31'b0, rst_req}, 32'd0);
            checkOutput("inreset_frame_err", {24'b0, frame_err}, 32'd0);
            checkOutput("inreset_ovf_err", {24'b0, ovf_err}, 32'd0);
        end else begin
            checkOutput("model_valid", {31'b0, cmdIf.cmd_valid}, {31'b0, mValid});
            if (mValid) checkOutput("model_data", cmdIf.cmd_data, mData);
            checkOutput("model_rst_req", {31'b0, rst_req}, {31'b0, (mRstCnt > 0)});
            checkOutput("model_frame_err", {24'b0, frame_err}, 32'(mFrameErr));
            checkOutput("model_ovf_err", {24'b0, ovf_err}, 32'(mOvfErr));
        end
        if (cmdIf.cmd_valid) begin
            validCount = validCount + 1;
            seenData   = cmdIf.cmd_data;
            if (firstValid < 0) firstValid = tickCount;
        end
        if (rst_req) begin
            rstHigh = rstHigh + 1;
            if (firstRst < 0) firstRst = tickCount;
        end
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Send one frame: start bit, LENGTH bits MSB first, stop bit.
    task automatic applyStimulus(input logic [31:0] word, input logic stopOk);
        if (nFrames < MAX_FRAMES) begin
            frames[nFrames].due    = cyc + LATENCY;
            frames[nFrames].word   = word;
            frames[nFrames].stopOk = stopOk;
            nFrames = nFrames + 1;
        end else begin
            checkOutput("frame_table_full", 32'(nFrames), 32'(MAX_FRAMES - 1));
        end
        ctrl = 1'b0;
        tick();
        for (int i = LENGTH - 1; i >= 0; i--) begin
            ctrl = word[i];
            tick();
        end
        ctrl = stopOk;
        tick();
        ctrl = 1'b1;
    endtask

    initial begin : mainProc
        int startTick;
        logic [31:0] partial;

        clearObs();
        cmdIf.cmd_ready = 1'b1;
        rst_n = 1'b0;
        waitCycles(3);
        rst_n = 1'b1;
        waitCycles(2);
        checkOutput("reset_valid", {31'b0, cmdIf.cmd_valid}, 32'd0);
        checkOutput("reset_rst_req", {31'b0, rst_req}, 32'd0);
        checkOutput("reset_frame_err", {24'b0, frame_err}, 32'd0);

        // 1: reset opcode stretches rst_req, nothing queued.
        $display("[TB] test 1: reset command");
        module_id = 4'h0;
        clearObs();
        startTick = tickCount;
        applyStimulus(32'hF000_0000, 1'b1);
        waitCycles(40);
        checkOutput("t1_rst_len", 32'(rstHigh), 32'd16);
        checkOutput("t1_rst_latency", 32'(firstRst - startTick), 32'd37);
        checkOutput("t1_no_valid", 32'(validCount), 32'd0);
        checkOutput("t1_ovf_err", {24'b0, ovf_err}, 32'd0);

        // 2: ADC read delivered with the expected latency.
        $display("[TB] test 2: single command latency");
        clearObs();
        startTick = tickCount;
        applyStimulus({CMD_MARKER, 4'h0, OP_ADC_READ, 20'h0_0000}, 1'b1);
        waitCycles(8);
        checkOutput("t2_latency", 32'(firstValid - startTick), 32'd37);
        checkOutput("t2_valid_cycles", 32'(validCount), 32'd1);
        checkOutput("t2_data", seenData, 32'hF020_0000);

        // 3: address filtering and broadcast.
        $display("[TB] test 3: addressing");
        clearObs();
        applyStimulus(32'hF120_0001, 1'b1);
        waitCycles(6);
        checkOutput("t3_wrong_addr", 32'(validCount), 32'd0);
        module_id = 4'h1;
        clearObs();
        applyStimulus(32'hF120_0001, 1'b1);
        waitCycles(6);
        checkOutput("t3_own_addr", 32'(validCount), 32'd1);
        checkOutput("t3_own_data", seenData, 32'hF120_0001);
        module_id = 4'h0;
        clearObs();
        applyStimulus(32'hFF20_0001, 1'b1);
        waitCycles(6);
        checkOutput("t3_bcast_data", seenData, 32'hFF20_0001);
        checkOutput("t3_frame_err", {24'b0, frame_err}, 32'd0);

        // 4: holding register full, back-to-back frames.
        $display("[TB] test 4: overflow");
        cmdIf.cmd_ready = 1'b0;
        applyStimulus(32'hF020_0001, 1'b1);
        applyStimulus(32'hF020_0002, 1'b1);
        waitCycles(6);
        checkOutput("t4_held_valid", {31'b0, cmdIf.cmd_valid}, 32'd1);
        checkOutput("t4_held_data", cmdIf.cmd_data, 32'hF020_0001);
        checkOutput("t4_ovf_err", {24'b0, ovf_err}, 32'd1);
        cmdIf.cmd_ready = 1'b1;
        tick();
        checkOutput("t4_drop_valid", {31'b0, cmdIf.cmd_valid}, 32'd0);

        // 5: bad stop bit and bad marker, then a good frame.
        $display("[TB] test 5: framing errors");
        clearObs();
        applyStimulus(32'hF020_0000, 1'b0);
        waitCycles(2);
        applyStimulus(32'h7020_0000, 1'b1);
        waitCycles(6);
        checkOutput("t5_frame_err", {24'b0, frame_err}, 32'd2);
        checkOutput("t5_nothing", 32'(validCount), 32'd0);
        applyStimulus(32'hF020_0003, 1'b1);
        waitCycles(6);
        checkOutput("t5_recover_data", seenData, 32'hF020_0003);
        checkOutput("t5_recover_count", 32'(validCount), 32'd1);

        // 6: reset in the middle of a frame, then resend.
        $display("[TB] test 6: reset mid-frame");
        partial = 32'hF020_0005;
        ctrl = 1'b0;
        tick();
        for (int i = LENGTH - 1; i >= LENGTH - 10; i--) begin
            ctrl = partial[i];
            tick();
        end
        rst_n = 1'b0;
        ctrl  = 1'b1;
        waitCycles(3);
        checkOutput("t6_reset_frame_err", {24'b0, frame_err}, 32'd0);
        checkOutput("t6_reset_ovf_err", {24'b0, ovf_err}, 32'd0);
        rst_n = 1'b1;
        waitCycles(3);
        clearObs();
        applyStimulus(partial, 1'b1);
        waitCycles(6);
        checkOutput("t6_resend_count", 32'(validCount), 32'd1);
        checkOutput("t6_resend_data", seenData, 32'hF020_0005);

        waitCycles(4);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
